pll_reset_sequencer: RTL
========================

# pll_reset_sequencer

Brings the design out of reset behind the 160 MHz / 20 MHz clock PLL: drives the PLL reset, synchronises and qualifies its `locked` output, and releases the system reset only after lock is stable. Runs on the free-running 50 MHz board reference clock, which is valid before lock, and sits directly downstream of the PLL wrapper. Retries the PLL on lock timeout and re-sequences on lock loss. Each consumer domain (160 MHz, 20 MHz) re-synchronises `sys_rst_n` locally.

## Interface
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronised-lock cycles required before release.
- `LOCK_TIMEOUT_CYCLES`, default 50000: cycles allowed in WAIT_LOCK, 1 ms at 50 MHz.
- `PLL_RST_CYCLES`, default 16: length of each `pll_rst` pulse.
- `MAX_RETRIES`, default 3: timeout retries before FAIL.
- `refclk`  in  1  50 MHz reference clock; the only clock.
- `rst`  in  1  reset; synchronous, active-low.
- `pll_locked`  in  1  PLL lock, asynchronous to `refclk`.
- `pll_rst`  out  1  active-high reset to the PLL.
- `sys_rst_n`  out  1  active-low system reset.
- `ready`  out  1  high only in RUN.
- `fail`  out  1  retries exhausted; sticky until `rst`.
- `lock_loss_count`  out  8  lock losses seen in RUN; saturates at 255.

## Operation
- `pll_locked` passes through a 2-flop synchroniser to give `lock_s`. No other logic samples `pll_locked`.
- One cycle counter, width `$clog2` of the largest parameter, plus a retry counter of width `$clog2(MAX_RETRIES+1)`.
- **PLL_RESET**: `pll_rst`=1, `sys_rst_n`=0. After `PLL_RST_CYCLES` cycles, go to WAIT_LOCK with the counter cleared.
- **WAIT_LOCK**: `pll_rst`=0.
  - `lock_s`=1: go to STABILIZE.
  - Else, counter reaches `LOCK_TIMEOUT_CYCLES` and retries < `MAX_RETRIES`: retries++, go to PLL_RESET.
  - Else, on timeout with retries == `MAX_RETRIES`: go to FAIL.
  - Lock and timeout in the same cycle: lock wins.
- **STABILIZE**: counts cycles with `lock_s`=1.
  - `lock_s`=0: go to WAIT_LOCK with a fresh timeout. Retries are not incremented.
  - Count reaches `LOCK_STABLE_CYCLES`: go to RUN and clear retries.
- **RUN**: `sys_rst_n`=1, `ready`=1. On `lock_s`=0, `lock_loss_count` increments (saturating) and the block goes to PLL_RESET.
- **FAIL**: `pll_rst`=1, `sys_rst_n`=0, `fail`=1. Exits only via `rst`.
- `rst`=0 at any point, in any state: the next edge restores every reset value, including both counters and `lock_loss_count`.

## Timing
- All outputs are registered and decoded from the next-state, so outputs change on the same edge as the state.
- Reset values: state PLL_RESET, `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fail`=0, `lock_loss_count`=0, synchroniser flops 0.
- While `rst`=0, `pll_rst` is held at 1. After release it stays 1 for exactly `PLL_RST_CYCLES` further edges.
- Lock to release: `pll_locked` rising at edge N, held high, gives `sys_rst_n` and `ready` rising at edge N+2+`LOCK_STABLE_CYCLES`+1.
- Lock loss: `pll_locked` falling at edge N gives `sys_rst_n`=0, `ready`=0, `pll_rst`=1 and the count update all at edge N+3.
- FAIL is entered on the edge after the final timeout count.
- Lock glitches shorter than one `refclk` period may be missed. This is acceptable.

## Structure
- Package `pll_seq_pkg` holds the state encoding localparams (PLL_RESET, WAIT_LOCK, STABILIZE, RUN, FAIL; 3 bits) and the `LOCK_LOSS_W`=8 constant.
- Sub-module `sync_2ff` implements the bit synchroniser. It has no reset-dependent behaviour beyond clearing to 0, and the other codebase CDC points reuse it.
- Target size is roughly 150 lines.

## Test plan
Bench parameters: `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32, `PLL_RST_CYCLES`=4, `MAX_RETRIES`=2.

- **Clean bring-up**: release `rst` at edge 0, raise `pll_locked` at edge 10 → `pll_rst` is high for edges 0–3, and `sys_rst_n`/`ready` rise at edge 21.
- **Glitch in STABILIZE**: after 5 locked cycles, drop `pll_locked` for 2 cycles → no release, `lock_loss_count`=0, and release occurs 11 edges after the re-rise.
- **Timeout retries**: `pll_locked` held 0 → exactly 3 `pll_rst` pulses of 4 cycles each, then `fail`=1 with `pll_rst`=1 held. `fail` clears only on `rst`.
- **Lock loss in RUN**: drop `pll_locked` → `sys_rst_n`=0 three edges later, `lock_loss_count` goes 0→1, a 4-cycle `pll_rst` pulse follows, and relock returns to RUN.
- **Saturation**: 260 loss/relock cycles → `lock_loss_count`=255.
- **Reset mid-operation**: assert `rst` in STABILIZE and in FAIL → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/pll_reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_seq_pkg
// Purpose  : Shared constants and types for the PLL reset sequencer. Holds the
//            3-bit state encoding, the lock-loss counter width, and a helper
//            used to size the shared cycle counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

  // State encoding, 3 bits.
  localparam logic [2:0] PLL_RESET = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] STABILIZE = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] FAIL      = 3'd4;

  // Width of the saturating lock-loss counter.
  localparam int LOCK_LOSS_W = 8;

  typedef enum logic [2:0] {
    S_PLL_RESET = PLL_RESET,
    S_WAIT_LOCK = WAIT_LOCK,
    S_STABILIZE = STABILIZE,
    S_RUN       = RUN,
    S_FAIL      = FAIL
  } seq_state_t;

  // Largest of three cycle-count parameters; sizes the one shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer_if
// Purpose  : Bundles the PLL-side and system-side signals of the reset
//            sequencer.
// Signals  : pll_locked      - PLL lock, asynchronous to refclk
//            pll_rst         - active-high reset to the PLL
//            sys_rst_n       - active-low system reset
//            ready           - high only while the system is running
//            fail            - sticky retry-exhausted flag
//            lock_loss_count - saturating count of lock losses while running
// Modports : master - the sequencer (drives the outputs, samples pll_locked)
//            slave  - the surrounding PLL wrapper / system
// Revision : 1.0 - initial release
// ============================================================================
interface pll_reset_sequencer_if;
  import pll_seq_pkg::*;

  logic                   pll_locked;
  logic                   pll_rst;
  logic                   sys_rst_n;
  logic                   ready;
  logic                   fail;
  logic [LOCK_LOSS_W-1:0] lock_loss_count;

  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_rst_n,
    output ready,
    output fail,
    output lock_loss_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_rst_n,
    input  ready,
    input  fail,
    input  lock_loss_count
  );

endinterface
`default_nettype wire

// File: rtl/pll_reset_sequencer_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop single-bit synchroniser. Reused at every CDC point of
//            the codebase. The only reset behaviour is clearing both flops.
// Ports    : clk - destination clock
//            rst - synchronous, active-low reset
//            i_d - asynchronous input bit
//            o_q - synchronised output bit
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_d,
  output logic      o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Purpose  : Sequences the PLL out of reset on the free-running reference
//            clock: pulses the PLL reset, waits for a synchronised lock,
//            requires the lock to hold for LOCK_STABLE_CYCLES, then releases
//            the system reset. Retries the PLL on lock timeout, gives up
//            after MAX_RETRIES, and re-sequences on lock loss while running.
// Ports    : refclk - 50 MHz reference clock, the only clock
//            rst    - synchronous, active-low reset
//            bus    - pll_reset_sequencer_if.master (PLL and system signals)
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int MAX_RETRIES         = 3
) (
  input  wire logic             refclk,
  input  wire logic             rst,
  pll_reset_sequencer_if.master bus
);

  localparam int MAX_CYC = max3(LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES, PLL_RST_CYCLES);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  // Terminal counts: the counter starts at 0 on state entry, so the last
  // cycle of an N-cycle interval is N-1.
  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  seq_state_t             r_state;
  seq_state_t             w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic [RETRY_W-1:0]     r_retry;
  logic [RETRY_W-1:0]     w_retry_next;
  logic                   w_loss;
  logic                   w_lock_s;

  logic                   r_pll_rst;
  logic                   r_sys_rst_n;
  logic                   r_ready;
  logic                   r_fail;
  logic [LOCK_LOSS_W-1:0] r_loss_cnt;

  // The only point where pll_locked enters the refclk domain.
  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .i_d (bus.pll_locked),
    .o_q (w_lock_s)
  );

  // Next-state, counter and retry logic.
  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt + CNT_W'(1);
    w_retry_next = r_retry;
    w_loss       = 1'b0;

    case (r_state)
      S_PLL_RESET: begin
        if (r_cnt == RST_LAST) begin
          w_next     = S_WAIT_LOCK;
          w_cnt_next = '0;
        end
      end

      S_WAIT_LOCK: begin
        // Lock takes priority over a timeout in the same cycle.
        if (w_lock_s) begin
          w_next     = S_STABILIZE;
          w_cnt_next = '0;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_cnt_next = '0;
          if (r_retry < RETRY_MAX) begin
            w_retry_next = r_retry + RETRY_W'(1);
            w_next       = S_PLL_RESET;
          end else begin
            w_next = S_FAIL;
          end
        end
      end

      S_STABILIZE: begin
        // A dropout restarts the wait with a fresh timeout but is not
        // charged as a retry.
        if (!w_lock_s) begin
          w_next     = S_WAIT_LOCK;
          w_cnt_next = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_next       = S_RUN;
          w_cnt_next   = '0;
          w_retry_next = '0;
        end
      end

      S_RUN: begin
        w_cnt_next = '0;
        if (!w_lock_s) begin
          w_next = S_PLL_RESET;
          w_loss = 1'b1;
        end
      end

      S_FAIL: begin
        w_cnt_next = '0;
      end

      default: begin
        w_next     = S_PLL_RESET;
        w_cnt_next = '0;
      end
    endcase
  end

  // State, counters and outputs. Outputs are decoded from the next state so
  // they change on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      r_state     <= S_PLL_RESET;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_loss_cnt  <= '0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_retry     <= w_retry_next;
      r_pll_rst   <= (w_next == S_PLL_RESET) || (w_next == S_FAIL);
      r_sys_rst_n <= (w_next == S_RUN);
      r_ready     <= (w_next == S_RUN);
      r_fail      <= (w_next == S_FAIL);
      if (w_loss && (r_loss_cnt != {LOCK_LOSS_W{1'b1}})) begin
        r_loss_cnt <= r_loss_cnt + LOCK_LOSS_W'(1);
      end
    end
  end

  assign bus.pll_rst         = r_pll_rst;
  assign bus.sys_rst_n       = r_sys_rst_n;
  assign bus.ready           = r_ready;
  assign bus.fail            = r_fail;
  assign bus.lock_loss_count = r_loss_cnt;

endmodule
`default_nettype wire
